// File: rtl/time_pkg.sv
// Shared definitions for the BCD time-field counters.
//   bcd_digit_t : one packed BCD digit (4 bits)
//   BCD_MAX     : largest legal BCD digit value
//   disp_t      : displayed digit pair plus pm flag
//   modulus_ok  : legality check for a field modulus (2..100)
//   to_12h      : maps a 24-hour count (BCD) onto the 12-hour display
package time_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
        logic       pm;
    } disp_t;

    // Two BCD digits cover 00..99, so the modulus tops out at 100.
    function automatic bit modulus_ok(input int unsigned modulus);
        return (modulus >= 2) && (modulus <= 100);
    endfunction

    // Works digit-wise on the BCD count so no binary stage is needed:
    // 00 -> 12 am, 01..11 -> as-is am, 12 -> 12 pm, 13..23 -> 01..11 pm.
    function automatic disp_t to_12h(input bcd_digit_t cnt_t, input bcd_digit_t cnt_o);
        disp_t d;
        d.tens = cnt_t;
        d.ones = cnt_o;
        d.pm   = 1'b0;
        case (cnt_t)
            4'd0: begin
                if (cnt_o == 4'd0) begin
                    d.tens = 4'd1;
                    d.ones = 4'd2;
                end
            end
            4'd1: begin
                if (cnt_o >= 4'd2) begin
                    d.pm = 1'b1;
                end
                if (cnt_o >= 4'd3) begin
                    d.tens = 4'd0;
                    d.ones = cnt_o - 4'd2;
                end
            end
            4'd2: begin
                d.pm = 1'b1;
                if (cnt_o <= 4'd1) begin
                    d.tens = 4'd0;
                    d.ones = cnt_o + 4'd8;
                end else begin
                    d.tens = 4'd1;
                    d.ones = cnt_o - 4'd2;
                end
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control and display bundle for one BCD time field.
//   en_in, key_up, key_dn, load, load_tens, load_ones, mode12 : driven by the master
//   tens, ones, pm, en_out, load_err                          : driven by the counter
// modport slave is used by the counter, modport master by whatever drives it.
interface bcd_mod_counter_if;
    import time_pkg::*;

    logic       en_in;
    logic       key_up;
    logic       key_dn;
    logic       load;
    bcd_digit_t load_tens;
    bcd_digit_t load_ones;
    logic       mode12;
    bcd_digit_t tens;
    bcd_digit_t ones;
    logic       pm;
    logic       en_out;
    logic       load_err;

    modport master (
        output en_in,
        output key_up,
        output key_dn,
        output load,
        output load_tens,
        output load_ones,
        output mode12,
        input  tens,
        input  ones,
        input  pm,
        input  en_out,
        input  load_err
    );

    modport slave (
        input  en_in,
        input  key_up,
        input  key_dn,
        input  load,
        input  load_tens,
        input  load_ones,
        input  mode12,
        output tens,
        output ones,
        output pm,
        output en_out,
        output load_err
    );

endinterface

// File: rtl/key_edge_sync.sv
// Synchronises a raw (already debounced) pushbutton and emits a one-cycle
// pulse on its rising edge.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears every flop
//   i_key   : asynchronous key level
//   o_pulse : one-cycle pulse, high KEY_SYNC edges after the key is first sampled high
module key_edge_sync #(
    parameter int unsigned KEY_SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_pulse
);

    logic [KEY_SYNC-1:0] r_sync;
    logic                r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[KEY_SYNC-2:0], i_key};
            r_prev <= r_sync[KEY_SYNC-1];
        end
    end

    // Decoded straight from flops so the event reaches the counter on the
    // very next edge; a held key yields only one pulse.
    assign o_pulse = r_sync[KEY_SYNC-1] & ~r_prev;

endmodule

// File: rtl/bcd_mod_counter.sv
// Modulo-MODULUS time-field counter held directly as two BCD digits.
// Usable as seconds, minutes or hours; fields cascade via en_in/en_out.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_mod_counter_if
//           en_in      count tick / carry from the lower field
//           key_up/dn  raw adjust buttons (synchronised here)
//           load       parallel load of load_tens/load_ones, validated
//           mode12     12-hour display mapping (only when MODULUS == 24)
//           tens/ones  registered display digits, pm registered flag
//           en_out     carry pulse on an en_in-driven wrap
//           load_err   pulse on a rejected load
// Per-cycle priority: load > key up > key down > en_in; lower ones are dropped.
module bcd_mod_counter
    import time_pkg::*;
#(
    parameter int unsigned MODULUS  = 24,
    parameter int unsigned KEY_SYNC = 2
) (
    input logic               clk,
    input logic               rst_n,
    bcd_mod_counter_if.slave  bus
);

    if (!modulus_ok(MODULUS)) begin : g_bad_modulus
        $error("bcd_mod_counter: MODULUS %0d outside 2..100", MODULUS);
    end

    if (KEY_SYNC < 2) begin : g_bad_key_sync
        $error("bcd_mod_counter: KEY_SYNC %0d below 2", KEY_SYNC);
    end

    localparam bcd_digit_t MAX_T     = bcd_digit_t'((MODULUS - 1) / 10);
    localparam bcd_digit_t MAX_O     = bcd_digit_t'((MODULUS - 1) % 10);
    localparam logic [7:0] MOD8      = 8'(MODULUS);
    localparam bit         MODE12_OK = (MODULUS == 24);

    bcd_digit_t r_cnt_t;
    bcd_digit_t r_cnt_o;
    bcd_digit_t r_tens;
    bcd_digit_t r_ones;
    logic       r_pm;
    logic       r_en_out;
    logic       r_load_err;

    logic       w_up_ev;
    logic       w_dn_ev;
    logic [7:0] w_load_val;
    logic       w_load_ok;
    logic       w_at_max;
    logic       w_at_zero;
    bcd_digit_t w_inc_t;
    bcd_digit_t w_inc_o;
    bcd_digit_t w_dec_t;
    bcd_digit_t w_dec_o;
    bcd_digit_t w_cnt_t_nxt;
    bcd_digit_t w_cnt_o_nxt;
    logic       w_en_out_nxt;
    logic       w_load_err_nxt;
    disp_t      w_disp;

    key_edge_sync #(
        .KEY_SYNC (KEY_SYNC)
    ) u_sync_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key   (bus.key_up),
        .o_pulse (w_up_ev)
    );

    key_edge_sync #(
        .KEY_SYNC (KEY_SYNC)
    ) u_sync_dn (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key   (bus.key_dn),
        .o_pulse (w_dn_ev)
    );

    // Load value is only used for the range check; 15*10+15 fits in 8 bits.
    assign w_load_val = ({4'd0, bus.load_tens} * 8'd10) + {4'd0, bus.load_ones};
    assign w_load_ok  = (bus.load_tens <= BCD_MAX) && (bus.load_ones <= BCD_MAX) &&
                        (w_load_val < MOD8);

    assign w_at_max  = (r_cnt_t == MAX_T) && (r_cnt_o == MAX_O);
    assign w_at_zero = (r_cnt_t == 4'd0) && (r_cnt_o == 4'd0);

    // BCD increment with wrap at MODULUS-1.
    always_comb begin
        w_inc_t = r_cnt_t;
        w_inc_o = r_cnt_o;
        if (w_at_max) begin
            w_inc_t = 4'd0;
            w_inc_o = 4'd0;
        end else if (r_cnt_o == BCD_MAX) begin
            w_inc_t = r_cnt_t + 4'd1;
            w_inc_o = 4'd0;
        end else begin
            w_inc_o = r_cnt_o + 4'd1;
        end
    end

    // BCD decrement with wrap from 00 to MODULUS-1.
    always_comb begin
        w_dec_t = r_cnt_t;
        w_dec_o = r_cnt_o;
        if (w_at_zero) begin
            w_dec_t = MAX_T;
            w_dec_o = MAX_O;
        end else if (r_cnt_o == 4'd0) begin
            w_dec_t = r_cnt_t - 4'd1;
            w_dec_o = BCD_MAX;
        end else begin
            w_dec_o = r_cnt_o - 4'd1;
        end
    end

    // One action per cycle; only an en_in wrap carries into the next field.
    always_comb begin
        w_cnt_t_nxt    = r_cnt_t;
        w_cnt_o_nxt    = r_cnt_o;
        w_en_out_nxt   = 1'b0;
        w_load_err_nxt = 1'b0;
        if (bus.load) begin
            if (w_load_ok) begin
                w_cnt_t_nxt = bus.load_tens;
                w_cnt_o_nxt = bus.load_ones;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (w_up_ev) begin
            w_cnt_t_nxt = w_inc_t;
            w_cnt_o_nxt = w_inc_o;
        end else if (w_dn_ev) begin
            w_cnt_t_nxt = w_dec_t;
            w_cnt_o_nxt = w_dec_o;
        end else if (bus.en_in) begin
            w_cnt_t_nxt  = w_inc_t;
            w_cnt_o_nxt  = w_inc_o;
            w_en_out_nxt = w_at_max;
        end
    end

    // Display follows the current count; mode12 only affects this mapping.
    always_comb begin
        w_disp = '{tens: r_cnt_t, ones: r_cnt_o, pm: 1'b0};
        if (MODE12_OK && bus.mode12) begin
            w_disp = to_12h(r_cnt_t, r_cnt_o);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_t    <= 4'd0;
            r_cnt_o    <= 4'd0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_pm       <= 1'b0;
            r_en_out   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_cnt_t    <= w_cnt_t_nxt;
            r_cnt_o    <= w_cnt_o_nxt;
            r_tens     <= w_disp.tens;
            r_ones     <= w_disp.ones;
            r_pm       <= w_disp.pm;
            r_en_out   <= w_en_out_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign bus.tens     = r_tens;
    assign bus.ones     = r_ones;
    assign bus.pm       = r_pm;
    assign bus.en_out   = r_en_out;
    assign bus.load_err = r_load_err;

endmodule
